// File: rtl/usb_rcv_ctrl.sv
// ----------------------------------------------------------------------------
// usb_rcv_ctrl
//
// Receive-side packet controller for a USB full-speed style decoder. It
// watches the decoder's bit/byte strobes, validates the sync byte, steers
// each data byte into a FIFO with a single write strobe, counts stored
// bytes, and flags malformed packets (bad sync, partial final byte,
// overflow) with a sticky error that clears on the next packet start.
//
// Parameters
//   SYNC_BYTE      expected value of rcv_data for the first byte of a packet
//   MAX_BYTES      maximum data bytes stored per packet (sync excluded)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   d_edge         1-cycle pulse: first line transition of a new packet
//   shift_enable   1-cycle pulse per bit-sample instant
//   eop            level: SE0 present on the line
//   byte_received  1-cycle pulse: rcv_data holds a complete byte
//   rcv_data[7:0]  received byte, valid with byte_received
//   rcving         packet reception in progress
//   w_enable       1-cycle FIFO write strobe for a data byte
//   r_error        sticky receive-error flag
//   byte_count[6:0] data bytes written in the current packet
// ----------------------------------------------------------------------------
module usb_rcv_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       shift_enable,
    input  logic       eop,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic [6:0] byte_count
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        SYNC_WAIT,
        SYNC_CHK,
        DATA_WAIT,
        STORE,
        EOP_END,
        ERR_WAIT,
        EIDLE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic [6:0] byte_count_nxt;
    logic       eop_seen;       // an EOP bit has been sampled in this packet
    logic       eop_seen_nxt;
    logic [7:0] sync_q;         // first byte of the packet, checked in SYNC_CHK
    logic       eop_bit;
    logic       at_max;

    assign eop_bit = eop & shift_enable;
    assign at_max  = (byte_count == MAX_CNT);

    // ------------------------------------------------------------------
    // Next-state and counter update
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned; otherwise a latch is inferred.
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        byte_count_nxt = byte_count;
        eop_seen_nxt   = eop_seen | eop_bit;

        case (state)
            IDLE, EIDLE: begin
                bit_cnt_nxt = 3'd0;
                if (d_edge) begin
                    state_nxt      = SYNC_WAIT;
                    byte_count_nxt = 7'd0;
                    eop_seen_nxt   = 1'b0;
                end
            end

            SYNC_WAIT: begin
                bit_cnt_nxt = 3'd0;
                if (byte_received)
                    state_nxt = SYNC_CHK;
                else if (eop_bit)
                    state_nxt = ERR_WAIT;
            end

            SYNC_CHK: begin
                bit_cnt_nxt = 3'd0;
                state_nxt   = (sync_q == SYNC_BYTE) ? DATA_WAIT : ERR_WAIT;
            end

            DATA_WAIT: begin
                // A completed byte outranks a coincident EOP bit; the EOP is
                // picked up again once STORE returns here.
                if (byte_received) begin
                    bit_cnt_nxt = 3'd0;
                    state_nxt   = STORE;
                end else begin
                    if (shift_enable)
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    // EOP on a byte boundary is a clean end; anywhere else
                    // a byte was cut short.
                    if (eop_bit)
                        state_nxt = (bit_cnt == 3'd0) ? EOP_END : ERR_WAIT;
                end
            end

            STORE: begin
                if (at_max) begin
                    state_nxt = ERR_WAIT;
                end else begin
                    byte_count_nxt = byte_count + 7'd1;
                    state_nxt      = DATA_WAIT;
                end
            end

            EOP_END: begin
                bit_cnt_nxt = 3'd0;
                if (!eop)
                    state_nxt = IDLE;
            end

            ERR_WAIT: begin
                // Hold off until the packet has actually ended on the line.
                bit_cnt_nxt = 3'd0;
                if (eop_seen && !eop)
                    state_nxt = EIDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            byte_count <= 7'd0;
            eop_seen   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            byte_count <= byte_count_nxt;
            eop_seen   <= eop_seen_nxt;
        end
    end

    // NOTE: pure data register with no reset; it is always loaded before
    // SYNC_CHK reads it, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (state == SYNC_WAIT && byte_received)
            sync_q <= rcv_data;
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign rcving   = (state != IDLE) && (state != EIDLE);
    assign r_error  = (state == ERR_WAIT) || (state == EIDLE);
    assign w_enable = (state == STORE) && !at_max;

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_usb_rcv_ctrl
//
// Packet-level bench for usb_rcv_ctrl. Packets are described by sync byte,
// data byte count, trailing partial bits and whether the last byte
// coincides with the first EOP bit; the expected writes, byte count and
// error outcome are derived from those rules directly. A negedge monitor
// counts write strobes and checks each one follows a byte_received.
// ----------------------------------------------------------------------------
module tb_usb_rcv_ctrl;

    localparam logic [7:0] SYNC = 8'h80;
    localparam int         MAXB = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_edge;
    logic       shift_enable;
    logic       eop;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [6:0] byte_count;

    int total  = 0;
    int bad    = 0;
    int wr_cnt = 0;
    logic br_prev = 1'b0;

    usb_rcv_ctrl #(.SYNC_BYTE(SYNC), .MAX_BYTES(MAXB)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_edge       (d_edge),
        .shift_enable (shift_enable),
        .eop          (eop),
        .byte_received(byte_received),
        .rcv_data     (rcv_data),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must come exactly one cycle after a byte_received.
    always @(negedge clk) begin
        if (w_enable === 1'b1) begin
            wr_cnt++;
            check("w_latency", 32'(br_prev), 32'd1);
        end
        br_prev = byte_received;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input int n);
        for (int b = 0; b < n; b++) begin
            shift_enable = 1'b1;
            d_edge       = ($urandom_range(0, 7) == 0);  // must be ignored
            step();
            shift_enable = 1'b0;
            d_edge       = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic send_byte(input logic [7:0] val, input bit coinc);
        shift_bits(8);
        byte_received = 1'b1;
        rcv_data      = val;
        if (coinc) begin
            eop          = 1'b1;
            shift_enable = 1'b1;
        end
        step();
        byte_received = 1'b0;
        shift_enable  = 1'b0;
        rcv_data      = 8'($urandom);
        step();
    endtask

    task automatic run_packet(input string tag, input logic [7:0] sync,
                              input int nbytes, input int p, input bit coinc);
        bit bad_sync;
        int exp_wr;
        bit exp_err;
        int wr0;
        int c;
        bad_sync = (sync != SYNC);
        exp_wr   = bad_sync ? 0 : ((nbytes > MAXB) ? MAXB : nbytes);
        exp_err  = bad_sync || (nbytes > MAXB) || (p != 0);
        wr0      = wr_cnt;

        d_edge = 1'b1;
        step();
        d_edge = 1'b0;
        check({tag, "_start_rcving"}, 32'(rcving), 32'd1);
        check({tag, "_start_err"},    32'(r_error), 32'd0);
        check({tag, "_start_cnt"},    32'(byte_count), 32'd0);

        shift_bits(8);
        byte_received = 1'b1;
        rcv_data      = sync;
        step();
        byte_received = 1'b0;
        check({tag, "_synchk_err"}, 32'(r_error), 32'd0);
        step();
        check({tag, "_sync_err"}, 32'(r_error), 32'(bad_sync));

        for (int i = 0; i < nbytes; i++) begin
            send_byte(8'($urandom), coinc && (i == nbytes - 1));
            c = bad_sync ? 0 : ((i + 1 > MAXB) ? MAXB : i + 1);
            check({tag, "_byte_cnt"}, 32'(byte_count), 32'(c));
            check({tag, "_byte_err"}, 32'(r_error), 32'(bad_sync || (i + 1 > MAXB)));
        end

        if (!coinc) begin
            shift_bits(p);
            eop          = 1'b1;
            shift_enable = 1'b1;
            step();
            shift_enable = 1'b0;
            step();
        end
        shift_enable = 1'b1;
        step();
        shift_enable = 1'b0;
        step();
        check({tag, "_eop_err"},    32'(r_error), 32'(exp_err));
        check({tag, "_eop_rcving"}, 32'(rcving), 32'd1);

        eop = 1'b0;
        step();
        step();
        check({tag, "_end_rcving"}, 32'(rcving), 32'd0);
        check({tag, "_end_err"},    32'(r_error), 32'(exp_err));
        check({tag, "_end_cnt"},    32'(byte_count), 32'(exp_wr));
        check({tag, "_writes"},     32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rcving"}, 32'(rcving), 32'd0);
        check({tag, "_wen"},    32'(w_enable), 32'd0);
        check({tag, "_err"},    32'(r_error), 32'd0);
        check({tag, "_cnt"},    32'(byte_count), 32'd0);
    endtask

    initial begin
        int wr0;
        logic [7:0] s;
        int n;
        int p;
        bit co;

        rst           = 1'b1;
        d_edge        = 1'b0;
        shift_enable  = 1'b0;
        eop           = 1'b0;
        byte_received = 1'b0;
        rcv_data      = 8'h00;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // Good packet, two data bytes, clean EOP.
        run_packet("good", SYNC, 2, 0, 1'b0);
        // Bad sync; the following packet's d_edge clears the error.
        run_packet("badsync", 8'h81, 1, 0, 1'b0);
        // One byte then a 3-bit fragment before EOP.
        run_packet("partial", SYNC, 1, 3, 1'b0);
        // 65 bytes: 64 stored, error on the 65th.
        run_packet("overflow", SYNC, 65, 0, 1'b0);
        // Last byte coincides with the first EOP bit.
        run_packet("coinc", SYNC, 2, 0, 1'b1);

        // Reset on the byte_received of the second data byte.
        wr0    = wr_cnt;
        d_edge = 1'b1;
        step();
        d_edge = 1'b0;
        shift_bits(8);
        byte_received = 1'b1;
        rcv_data      = SYNC;
        step();
        byte_received = 1'b0;
        step();
        send_byte(8'h5A, 1'b0);
        shift_bits(8);
        byte_received = 1'b1;
        rst           = 1'b1;
        step();
        byte_received = 1'b0;
        rst           = 1'b0;
        check_all_zero("rst_data");
        step();
        check("rst_data_wen2", 32'(w_enable), 32'd0);
        check("rst_data_writes", 32'(wr_cnt - wr0), 32'd1);

        // Reset while in SYNC_CHK.
        wr0    = wr_cnt;
        d_edge = 1'b1;
        step();
        d_edge = 1'b0;
        shift_bits(8);
        byte_received = 1'b1;
        rcv_data      = SYNC;
        step();
        byte_received = 1'b0;
        rst           = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("rst_synchk");
        repeat (3) step();
        check("rst_synchk_writes", 32'(wr_cnt - wr0), 32'd0);

        // Reset from EIDLE clears the sticky error.
        run_packet("pre_rst", 8'h00, 0, 0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("rst_eidle");

        // Randomised packets.
        for (int k = 0; k < 10; k++) begin
            s  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : SYNC;
            n  = $urandom_range(0, 5);
            p  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
            co = (s == SYNC) && (n > 0) && (p == 0) && ($urandom_range(0, 1) == 1);
            run_packet("rand", s, n, p, co);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_rcv_ctrl.md
USB_RCV_CTRL -- requirements
Module: usb_rcv_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h80, the expected sync pattern as seen at rcv_data after the first received byte.
REQ-002 SHALL have parameter MAX_BYTES, default 64, the maximum data bytes per packet, sync byte excluded.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port d_edge  input  1  one-cycle pulse: first line transition of a new packet.
REQ-006 SHALL have port shift_enable  input  1  one-cycle pulse per bit-sample instant.
REQ-007 SHALL have port eop  input  1  level: SE0 (end-of-packet) present on line.
REQ-008 SHALL have port byte_received  input  1  one-cycle pulse: rcv_data holds a complete byte.
REQ-009 SHALL have port rcv_data  input  8  shift-register byte; valid only while byte_received=1.
REQ-010 SHALL have port rcving  output  1  packet reception in progress; gates the decoder.
REQ-011 SHALL have port w_enable  output  1  one-cycle FIFO write strobe for a data byte.
REQ-012 SHALL have port r_error  output  1  sticky receive-error flag.
REQ-013 SHALL have port byte_count  output  7  data bytes written in the current packet.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, SYNC_WAIT, SYNC_CHK, DATA_WAIT, STORE, EOP_END, ERR_WAIT, EIDLE; all outputs decoded from registered state and counters.
REQ-015 IDLE: rcving=0, r_error=0; d_edge -> SYNC_WAIT and byte_count cleared to 0.
REQ-016 SYNC_WAIT: rcving=1; byte_received -> SYNC_CHK with rcv_data latched; eop & shift_enable -> ERR_WAIT.
REQ-017 SYNC_CHK (exactly 1 cycle): latched byte == SYNC_BYTE -> DATA_WAIT, else -> ERR_WAIT.
REQ-018 DATA_WAIT: 3-bit bit_cnt increments on each shift_enable (mod 8) and clears on byte_received; byte_received -> STORE.
REQ-019 DATA_WAIT with eop & shift_enable: bit_cnt==0 -> EOP_END; bit_cnt!=0 (partial byte) -> ERR_WAIT.
REQ-020 If byte_received and eop & shift_enable occur in the same cycle in DATA_WAIT, byte_received SHALL win (-> STORE); the EOP is re-evaluated from STORE's successor state.
REQ-021 STORE (exactly 1 cycle): w_enable=1, byte_count increments by 1; byte_count was already MAX_BYTES -> no write (w_enable=0), -> ERR_WAIT; otherwise -> DATA_WAIT.
REQ-022 byte_count SHALL saturate at MAX_BYTES and never wrap.
REQ-023 w_enable SHALL be 1 only in STORE, hence at most one pulse per byte_received, asserted the cycle after it.
REQ-024 EOP_END: rcving=1; remain while eop=1; eop=0 -> IDLE (rcving falls the following cycle); byte_count holds until next d_edge.
REQ-025 ERR_WAIT: r_error=1, rcving=1; ignore byte_received (no writes); eop & shift_enable seen, then eop=0 -> EIDLE.
REQ-026 EIDLE: r_error=1, rcving=0; d_edge -> SYNC_WAIT with r_error cleared and byte_count cleared.
REQ-027 d_edge SHALL be ignored in every state except IDLE and EIDLE.
REQ-028 Receive-to-write latency SHALL be exactly 1 cycle (byte_received at cycle N -> w_enable at N+1).

Reset
REQ-029 rst=1 at a rising clk edge SHALL force IDLE, bit_cnt=0, byte_count=0, rcving=0, w_enable=0, r_error=0 on the next cycle, regardless of state, including mid-packet or mid-STORE.
REQ-030 rst SHALL take priority over all other inputs in the same cycle; no w_enable pulse SHALL follow a reset asserted during SYNC_CHK or DATA_WAIT.

Verification
REQ-031 Good packet: d_edge, byte 8'h80, bytes 8'hA5, 8'h3C, EOP after 16 data shifts -> 2 w_enable pulses, byte_count=2, r_error=0, rcving returns to 0 after eop falls.
REQ-032 Bad sync: d_edge, first byte 8'h81 -> no w_enable, r_error=1 from SYNC_CHK+1, EIDLE after EOP; next d_edge clears r_error.
REQ-033 Partial byte: valid sync, one byte, then 3 shifts and eop & shift_enable -> 1 w_enable, r_error=1, byte_count=1.
REQ-034 Overflow: valid sync then 65 bytes -> exactly 64 w_enable pulses, byte_count=64, r_error=1 on the 65th.
REQ-035 Simultaneous byte_received and eop & shift_enable in DATA_WAIT with bit_cnt=0 -> byte stored, then EOP_END, r_error=0.
REQ-036 Reset mid-packet: rst asserted the cycle of a byte_received in DATA_WAIT -> no w_enable, all outputs 0 next cycle, IDLE.
